// File: rtl/serial_word_comparator.sv
// rtl/serial_word_comparator.sv - MSB-first serial magnitude comparator driving an external 2-bit comparator
module serial_word_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [1:0]       slice_a,
    output logic [1:0]       slice_b,
    input  logic             cmp_g,
    input  logic             cmp_e,
    input  logic             cmp_l,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             err
);

    localparam int NSLICE = WIDTH / 2;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             err_q, err_d;
    logic [2:0]       resp;
    logic             one_hot;

    assign resp    = {cmp_g, cmp_e, cmp_l};
    assign one_hot = (resp == 3'b100) || (resp == 3'b010) || (resp == 3'b001);

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d    = a_in;
                    sb_d    = b_in;
                    cnt_d   = CW'(NSLICE - 1);
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // A malformed comparator response ends the compare with no magnitude verdict.
                if (!one_hot) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (cmp_g) begin
                    gt_d    = 1'b1;
                    state_d = S_DONE;
                end else if (cmp_l) begin
                    lt_d    = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == '0) begin
                    eq_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    sa_d  = sa_q << 2;
                    sb_d  = sb_q << 2;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            err_q   <= err_d;
        end
    end

    assign slice_a = sa_q[WIDTH-1:WIDTH-2];
    assign slice_b = sb_q[WIDTH-1:WIDTH-2];
    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign gt      = gt_q;
    assign eq      = eq_q;
    assign lt      = lt_q;
    assign err     = err_q;

endmodule

// File: tb/tb_serial_word_comparator.sv
// tb/tb_serial_word_comparator.sv - randomized model-checked bench for serial_word_comparator
module tb_serial_word_comparator;

    localparam int W  = 8;
    localparam int NS = W / 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [1:0]   slice_a, slice_b;
    logic         cmp_g, cmp_e, cmp_l;
    logic         busy, done, gt, eq, lt, err;

    logic         fault_en = 1'b0;
    logic [2:0]   fault_val = 3'b000;

    int checks = 0;
    int passes = 0;
    bit chk_en = 1'b0;

    serial_word_comparator #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .slice_a(slice_a), .slice_b(slice_b),
        .cmp_g(cmp_g), .cmp_e(cmp_e), .cmp_l(cmp_l),
        .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt), .err(err)
    );

    // Stand-in for the external 2-bit comparator, with a fault override.
    assign {cmp_g, cmp_e, cmp_l} = fault_en ? fault_val :
        {slice_a > slice_b, slice_a == slice_b, slice_a < slice_b};

    always #5 clk = ~clk;

    function automatic logic [1:0] slice_of(input logic [W-1:0] x, input int j);
        logic [W-1:0] t;
        t = x >> (W - 2 * j);
        return t[1:0];
    endfunction

    function automatic int first_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int j = 1; j <= NS; j++)
            if (slice_of(a, j) != slice_of(b, j)) return j;
        return 0;
    endfunction

    // Model: phase 0 idle, 1 running (m_j = current slice), 2 done cycle.
    int           m_phase = 0;
    int           m_j = 0;
    int           m_k = 0;
    bit           m_have = 1'b0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic [3:0]   m_res = '0;
    logic [3:0]   m_vout = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_have  <= 1'b0;
            m_vout  <= '0;
            m_j     <= 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    int fd;
                    fd = first_diff(a_in, b_in);
                    m_a     <= a_in;
                    m_b     <= b_in;
                    m_have  <= 1'b1;
                    m_j     <= 1;
                    m_vout  <= '0;
                    m_phase <= 1;
                    if (fault_en) begin
                        m_k <= 1; m_res <= 4'b0001;
                    end else if (fd == 0) begin
                        m_k <= NS; m_res <= 4'b0100;
                    end else begin
                        m_k <= fd; m_res <= (a_in > b_in) ? 4'b1000 : 4'b0010;
                    end
                end
                1: if (m_j == m_k) begin
                    m_phase <= 2;
                    m_vout  <= m_res;
                end else begin
                    m_j <= m_j + 1;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [1:0] esa, esb;
            esa = m_have ? slice_of(m_a, m_j) : 2'b00;
            esb = m_have ? slice_of(m_b, m_j) : 2'b00;
            chk("busy", 8'(busy), 8'(m_phase == 1));
            chk("done", 8'(done), 8'(m_phase == 2));
            chk("verdict", {4'h0, gt, eq, lt, err}, {4'h0, (m_phase == 1) ? 4'b0000 : m_vout});
            chk("slice_a", 8'(slice_a), 8'(esa));
            chk("slice_b", 8'(slice_b), 8'(esb));
        end
    end

    task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit lit,
                           input int exp_busy, input logic [3:0] exp_v, input bit poke);
        int nb;
        bit seen;
        nb = 0;
        seen = 1'b0;
        @(negedge clk);
        a_in = a; b_in = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            a_in = ~a; b_in = ~b; start = 1'b1;
        end
        for (int i = 0; i < 40 && !seen; i++) begin
            if (busy) nb++;
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_seen", 8'(seen), 8'd1);
        if (lit) begin
            chk("busy_cycles", 8'(nb), 8'(exp_busy));
            chk("lit_verdict", {4'h0, gt, eq, lt, err}, {4'h0, exp_v});
        end
    endtask

    initial begin
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_outs", {2'b0, busy, done, gt, eq, lt, err}, 8'h00);
        chk("rst_slices", {4'h0, slice_a, slice_b}, 8'h00);

        run_cmp(8'hA5, 8'h5A, 1'b1, 1, 4'b1000, 1'b0);
        run_cmp(8'h3C, 8'h3C, 1'b1, 4, 4'b0100, 1'b0);
        run_cmp(8'h34, 8'h37, 1'b1, 4, 4'b0010, 1'b0);
        run_cmp(8'h34, 8'h37, 1'b1, 4, 4'b0010, 1'b0);
        run_cmp(8'h01, 8'h02, 1'b1, 4, 4'b0010, 1'b1);

        // Abort on the second RUN cycle.
        @(negedge clk);
        a_in = 8'hFF; b_in = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outs", {2'b0, busy, done, gt, eq, lt, err}, 8'h00);
        chk("abort_slices", {4'h0, slice_a, slice_b}, 8'h00);
        run_cmp(8'h80, 8'h7F, 1'b1, 1, 4'b1000, 1'b0);

        fault_en = 1'b1; fault_val = 3'b000;
        run_cmp(8'h12, 8'h12, 1'b1, 1, 4'b0001, 1'b0);
        fault_en = 1'b0;
        run_cmp(8'h40, 8'h41, 1'b1, 4, 4'b0010, 1'b0);
        fault_en = 1'b1; fault_val = 3'b110;
        run_cmp(8'hC0, 8'h00, 1'b1, 1, 4'b0001, 1'b0);
        fault_en = 1'b0;
        run_cmp(8'hC0, 8'h00, 1'b1, 1, 4'b1000, 1'b0);

        for (int n = 0; n < 80; n++) begin
            logic [W-1:0] a, b;
            int sel;
            a = W'($urandom);
            sel = $urandom_range(0, 3);
            if (sel == 0) b = W'($urandom);
            else if (sel == 1) b = a;
            else begin
                int j;
                j = $urandom_range(1, NS);
                b = a ^ (W'($urandom_range(1, 3)) << (W - 2 * j));
            end
            run_cmp(a, b, 1'b0, 0, 4'b0000, ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                @(negedge clk);
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
